// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: bus-cycle engine for the external RTC.
// Turns one access request into a multiplexed address/data cycle on CS_n/RD_n/WR_n/AD_n/AD.
// Every bus output is registered. It is computed from the next state, so that
// strobes change exactly on state boundaries and cannot glitch.
module rtc_bus_ctrl #(
  parameter int unsigned T_LOW  = 10,
  parameter int unsigned T_HOLD = 4,
  parameter int unsigned T_GAP  = 6,
  parameter int unsigned CW     = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Acceso,
  input  logic       Mod,
  input  logic [6:0] Dir,
  input  logic [7:0] data_wr,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       AD_n,
  output logic [7:0] data_rd,
  output logic       rd_valid,
  output logic       busy,
  output logic       FRW
);

  localparam int unsigned DW = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    A_LOW  = 3'd1,
    A_HOLD = 3'd2,
    GAP    = 3'd3,
    D_LOW  = 3'd4,
    D_HOLD = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            acc_q;
  logic            start;

  // Request latched at start; held for the whole transaction.
  logic [DW-1:0]   addr, addr_nx;
  logic [DW-1:0]   wdat, wdat_nx;
  logic            wr_op, wr_op_nx;

  // Next values of the registered outputs.
  logic [DW-1:0]   nx_out;
  logic            nx_oe;
  logic            nx_cs_n;
  logic            nx_rd_n;
  logic            nx_wr_n;
  logic            nx_ad_n;
  logic [DW-1:0]   nx_rdata;
  logic            nx_rdv;
  logic            nx_busy;
  logic            nx_frw;

  // Edge detect on the request; only honoured while idle.
  always_comb begin
    start    = Acceso & ~acc_q & (state == IDLE);
    addr_nx  = start ? {1'b0, Dir} : addr;
    wdat_nx  = start ? data_wr : wdat;
    wr_op_nx = start ? Mod : wr_op;
  end

  // Next-state and phase counter: each state reloads the counter on entry and leaves at zero.
  always_comb begin
    state_d = state;
    cnt_d   = (cnt == '0) ? '0 : cnt - CW'(1);
    case (state)
      IDLE: begin
        if (start) begin
          state_d = A_LOW;
          cnt_d   = CW'(T_LOW - 1);
        end
      end
      A_LOW: begin
        if (cnt == '0) begin
          state_d = A_HOLD;
          cnt_d   = CW'(T_HOLD - 1);
        end
      end
      A_HOLD: begin
        if (cnt == '0) begin
          state_d = GAP;
          cnt_d   = CW'(T_GAP - 1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_d = D_LOW;
          cnt_d   = CW'(T_LOW - 1);
        end
      end
      D_LOW: begin
        if (cnt == '0) begin
          state_d = D_HOLD;
          cnt_d   = CW'(T_HOLD - 1);
        end
      end
      D_HOLD: begin
        if (cnt == '0) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Bus output decode from the state being entered.
  always_comb begin
    nx_out   = '0;
    nx_oe    = 1'b0;
    nx_cs_n  = 1'b1;
    nx_rd_n  = 1'b1;
    nx_wr_n  = 1'b1;
    nx_ad_n  = 1'b1;
    nx_rdv   = 1'b0;
    nx_frw   = 1'b0;
    nx_busy  = (state_d != IDLE);
    nx_rdata = data_rd;
    if ((state == D_LOW) && (cnt == '0) && !wr_op) begin
      nx_rdata = ad_in;
    end
    case (state_d)
      A_LOW: begin
        nx_ad_n = 1'b0;
        nx_cs_n = 1'b0;
        nx_wr_n = 1'b0;
        nx_oe   = 1'b1;
        nx_out  = addr_nx;
      end
      A_HOLD: begin
        nx_ad_n = 1'b0;
        nx_oe   = 1'b1;
        nx_out  = addr_nx;
      end
      D_LOW: begin
        nx_cs_n = 1'b0;
        if (wr_op_nx) begin
          nx_wr_n = 1'b0;
          nx_oe   = 1'b1;
          nx_out  = wdat_nx;
        end else begin
          nx_rd_n = 1'b0;
        end
      end
      D_HOLD: begin
        if (wr_op_nx) begin
          nx_oe  = 1'b1;
          nx_out = wdat_nx;
        end
      end
      DONE: begin
        nx_frw = 1'b1;
        nx_rdv = ~wr_op_nx;
      end
      default: begin
      end
    endcase
  end

  // State register, phase counter and request edge register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      acc_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      acc_q <= Acceso;
    end
  end

  // Transaction parameters captured at start.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr  <= '0;
      wdat  <= '0;
      wr_op <= 1'b0;
    end else begin
      addr  <= addr_nx;
      wdat  <= wdat_nx;
      wr_op <= wr_op_nx;
    end
  end

  // Registered outputs; reset releases the bus at the reset edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ad_out   <= '0;
      ad_oe    <= 1'b0;
      CS_n     <= 1'b1;
      RD_n     <= 1'b1;
      WR_n     <= 1'b1;
      AD_n     <= 1'b1;
      data_rd  <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      FRW      <= 1'b0;
    end else begin
      ad_out   <= nx_out;
      ad_oe    <= nx_oe;
      CS_n     <= nx_cs_n;
      RD_n     <= nx_rd_n;
      WR_n     <= nx_wr_n;
      AD_n     <= nx_ad_n;
      data_rd  <= nx_rdata;
      rd_valid <= nx_rdv;
      busy     <= nx_busy;
      FRW      <= nx_frw;
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl: outputs are sampled on the falling edge
// against a per-cycle timeline of the bus cycle, using the default timing of 10/4/6.
module tb_rtc_bus_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Acceso;
  logic       Mod;
  logic [6:0] Dir;
  logic [7:0] data_wr;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic       AD_n;
  logic [7:0] data_rd;
  logic       rd_valid;
  logic       busy;
  logic       FRW;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int frw_cyc = 0;

  always #5 CLK = ~CLK;

  // Free-running cycle counter for measuring distances between events.
  always @(posedge CLK) cyc <= cyc + 1;

  rtc_bus_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .Acceso   (Acceso),
    .Mod      (Mod),
    .Dir      (Dir),
    .data_wr  (data_wr),
    .ad_in    (ad_in),
    .ad_out   (ad_out),
    .ad_oe    (ad_oe),
    .CS_n     (CS_n),
    .RD_n     (RD_n),
    .WR_n     (WR_n),
    .AD_n     (AD_n),
    .data_rd  (data_rd),
    .rd_valid (rd_valid),
    .busy     (busy),
    .FRW      (FRW)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " cs_n"},  32'(CS_n),  32'd1);
    chk({tag, " rd_n"},  32'(RD_n),  32'd1);
    chk({tag, " wr_n"},  32'(WR_n),  32'd1);
    chk({tag, " ad_n"},  32'(AD_n),  32'd1);
    chk({tag, " ad_oe"}, 32'(ad_oe), 32'd0);
    chk({tag, " busy"},  32'(busy),  32'd0);
    chk({tag, " frw"},   32'(FRW),   32'd0);
  endtask

  // Starts a transaction at the current falling edge and checks cycles 1..stop_k.
  task automatic run_txn(input string name, input logic wr, input logic [6:0] dir,
                         input logic [7:0] wd, input logic [7:0] rdin,
                         input logic [7:0] rd_prev, input int stop_k, input bit glitch);
    logic       e_cs, e_rd, e_wr, e_adn, e_oe, e_frw, e_rdv;
    logic [7:0] e_out, e_drd;
    Mod     = wr;
    Dir     = dir;
    data_wr = wd;
    ad_in   = ~rdin;
    Acceso  = 1'b1;
    for (int k = 1; k <= stop_k; k++) begin
      @(negedge CLK);
      // Scramble request inputs to confirm they were latched at start.
      Mod     = ~wr;
      Dir     = ~dir;
      data_wr = ~wd;
      ad_in   = (k >= 21 && k <= 30) ? rdin : ~rdin;
      if (glitch && k == 19) Acceso = 1'b0;
      if (glitch && k == 20) Acceso = 1'b1;
      e_cs = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_adn = 1'b1;
      e_oe = 1'b0; e_out = 8'h00; e_frw = 1'b0; e_rdv = 1'b0;
      if (k <= 10) begin
        e_cs = 1'b0; e_wr = 1'b0; e_adn = 1'b0; e_oe = 1'b1; e_out = {1'b0, dir};
      end else if (k <= 14) begin
        e_adn = 1'b0; e_oe = 1'b1; e_out = {1'b0, dir};
      end else if (k <= 20) begin
        e_adn = 1'b1;
      end else if (k <= 30) begin
        e_cs = 1'b0;
        if (wr) begin
          e_wr = 1'b0; e_oe = 1'b1; e_out = wd;
        end else begin
          e_rd = 1'b0;
        end
      end else if (k <= 34) begin
        if (wr) begin
          e_oe = 1'b1; e_out = wd;
        end
      end else begin
        e_frw = 1'b1; e_rdv = ~wr;
      end
      e_drd = (!wr && k >= 31) ? rdin : rd_prev;
      chk($sformatf("%s k=%0d cs_n", name, k),  32'(CS_n),     32'(e_cs));
      chk($sformatf("%s k=%0d rd_n", name, k),  32'(RD_n),     32'(e_rd));
      chk($sformatf("%s k=%0d wr_n", name, k),  32'(WR_n),     32'(e_wr));
      chk($sformatf("%s k=%0d ad_n", name, k),  32'(AD_n),     32'(e_adn));
      chk($sformatf("%s k=%0d ad_oe", name, k), 32'(ad_oe),    32'(e_oe));
      chk($sformatf("%s k=%0d busy", name, k),  32'(busy),     32'd1);
      chk($sformatf("%s k=%0d frw", name, k),   32'(FRW),      32'(e_frw));
      chk($sformatf("%s k=%0d rdv", name, k),   32'(rd_valid), 32'(e_rdv));
      chk($sformatf("%s k=%0d data_rd", name, k), 32'(data_rd), 32'(e_drd));
      if (e_oe) chk($sformatf("%s k=%0d ad_out", name, k), 32'(ad_out), 32'(e_out));
      if (k == 35 && FRW) frw_cyc = cyc;
    end
  endtask

  initial begin
    int extra_frw;
    int extra_busy;
    int first_frw;
    RST     = 1'b1;
    Acceso  = 1'b0;
    Mod     = 1'b0;
    Dir     = 7'h00;
    data_wr = 8'h00;
    ad_in   = 8'h00;

    // 1: reset values, then an idle bus for 10 cycles.
    repeat (2) @(negedge CLK);
    idle_chk("rst");
    chk("rst ad_out",   32'(ad_out),   32'h00);
    chk("rst data_rd",  32'(data_rd),  32'h00);
    chk("rst rd_valid", 32'(rd_valid), 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      idle_chk($sformatf("idle%0d", i));
    end

    // 2: write 0x45 to register 0x21.
    run_txn("wr21", 1'b1, 7'h21, 8'h45, 8'h00, 8'h00, 35, 1'b0);
    @(negedge CLK);
    idle_chk("wr21 end");
    Acceso = 1'b0;
    @(negedge CLK);

    // 3: read register 0x41, pad returns 0x59.
    run_txn("rd41", 1'b0, 7'h41, 8'h00, 8'h59, 8'h00, 35, 1'b0);
    @(negedge CLK);
    idle_chk("rd41 end");
    chk("rd41 data_rd hold", 32'(data_rd), 32'h59);
    Acceso = 1'b0;
    @(negedge CLK);

    // 4a: Acceso held high 100 cycles -> one transaction; data_rd untouched by a write.
    run_txn("hold", 1'b1, 7'h7F, 8'hC3, 8'h00, 8'h59, 35, 1'b0);
    extra_frw  = 0;
    extra_busy = 0;
    for (int i = 0; i < 65; i++) begin
      @(negedge CLK);
      if (FRW)  extra_frw++;
      if (busy) extra_busy++;
    end
    chk("hold extra frw",  32'(extra_frw),  32'd0);
    chk("hold extra busy", 32'(extra_busy), 32'd0);
    chk("hold data_rd",    32'(data_rd),    32'h59);
    Acceso = 1'b0;
    @(negedge CLK);

    // 4b: second rising edge at cycle 20 of a read is ignored.
    run_txn("glitch", 1'b0, 7'h15, 8'h00, 8'hA6, 8'h59, 35, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      idle_chk($sformatf("glitch post%0d", i));
    end
    chk("glitch data_rd", 32'(data_rd), 32'hA6);
    Acceso = 1'b0;
    @(negedge CLK);

    // 5: reset during D_LOW of a write aborts it at once.
    run_txn("abort", 1'b1, 7'h33, 8'h99, 8'h00, 8'hA6, 25, 1'b0);
    RST    = 1'b1;
    Acceso = 1'b0;
    @(negedge CLK);
    idle_chk("abort rst");
    chk("abort data_rd", 32'(data_rd), 32'h00);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      idle_chk($sformatf("abort post%0d", i));
    end
    run_txn("fresh", 1'b1, 7'h0A, 8'h5C, 8'h00, 8'h00, 35, 1'b0);
    @(negedge CLK);
    idle_chk("fresh end");
    Acceso = 1'b0;
    @(negedge CLK);

    // 6: back-to-back with Acceso low one cycle between; FRW pulses 37 apart.
    run_txn("b2b1", 1'b1, 7'h01, 8'hF0, 8'h00, 8'h00, 35, 1'b0);
    first_frw = frw_cyc;
    @(negedge CLK);
    idle_chk("b2b gap");
    Acceso = 1'b0;
    @(negedge CLK);
    run_txn("b2b2", 1'b1, 7'h02, 8'h0F, 8'h00, 8'h00, 35, 1'b0);
    chk("b2b frw spacing", 32'(frw_cyc - first_frw), 32'd37);
    @(negedge CLK);
    idle_chk("b2b end");
    Acceso = 1'b0;
    repeat (2) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
